// File: rtl/can_pkg.sv
// ----------------------------------------------------------------------------
// can_pkg
// Shared definitions for the CAN transmit scheduler slice.
//   CAN_ID_W / CAN_DLC_W / CAN_DATA_W : standard-frame field widths
//   sched_state_t                     : scheduler FSM states
//   can_frame_t                       : latched frame {id, dlc, data}
// ----------------------------------------------------------------------------
package can_pkg;

    localparam int CAN_ID_W   = 11;
    localparam int CAN_DLC_W  = 4;
    localparam int CAN_DATA_W = 64;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        LAUNCH,
        WAIT_DONE,
        IFS
    } sched_state_t;

    typedef struct packed {
        logic [CAN_ID_W-1:0]   id;
        logic [CAN_DLC_W-1:0]  dlc;
        logic [CAN_DATA_W-1:0] data;
    } can_frame_t;

endpackage

// File: rtl/can_prio_sel.sv
// ----------------------------------------------------------------------------
// can_prio_sel
// Combinational arbiter: among requesting mailboxes, picks the one with the
// numerically smallest identifier (CAN bus priority). Ties resolve to the
// lowest mailbox index.
//   i_Req   : request per mailbox
//   i_Id    : packed identifiers, mailbox k at [11k+10:11k]
//   o_Valid : at least one request present
//   o_Grant : one-hot grant of the winner (all zero when !o_Valid)
//   o_Idx   : index of the winner
// ----------------------------------------------------------------------------
module can_prio_sel
    import can_pkg::*;
#(
    parameter int NUM_MBOX = 4,
    parameter int IDX_W    = (NUM_MBOX > 1) ? $clog2(NUM_MBOX) : 1
) (
    input  logic [NUM_MBOX-1:0]          i_Req,
    input  logic [CAN_ID_W*NUM_MBOX-1:0] i_Id,
    output logic                         o_Valid,
    output logic [NUM_MBOX-1:0]          o_Grant,
    output logic [IDX_W-1:0]             o_Idx
);

    logic [CAN_ID_W-1:0] w_Best_Id;

    always_comb begin
        o_Valid   = 1'b0;
        o_Grant   = '0;
        o_Idx     = '0;
        w_Best_Id = '1;
        // Strict '<' keeps the earlier (lower-index) mailbox on equal ids.
        for (int unsigned k = 0; k < NUM_MBOX; k++) begin
            if (i_Req[k] && (!o_Valid || (i_Id[CAN_ID_W*k +: CAN_ID_W] < w_Best_Id))) begin
                o_Valid   = 1'b1;
                w_Best_Id = i_Id[CAN_ID_W*k +: CAN_ID_W];
                o_Idx     = IDX_W'(k);
            end
        end
        o_Grant[o_Idx] = o_Valid;
    end

endmodule

// File: rtl/can_tx_sched.sv
// ----------------------------------------------------------------------------
// can_tx_sched
// Shares one can_tx serializer between NUM_MBOX transmit mailboxes. Picks the
// pending frame with the lowest identifier, launches it with a one-cycle
// o_Tx_DV, waits for i_Tx_Done, retries unacknowledged frames up to MAX_RETRY
// times, enforces an interframe space and reports done/error per mailbox.
//   i_Clock, i_Rst_n        : clock, asynchronous active-low reset
//   i_Req/i_Id/i_Len/i_Data : host mailbox requests and packed frame fields
//   o_Done / o_Err          : one-cycle per-mailbox completion pulses
//   o_Busy                  : scheduler not idle
//   o_Tx_DV/Id/Len/Data     : launch strobe and latched frame to can_tx
//   i_Tx_Done / i_Tx_Ack    : end-of-frame pulse and ACK status from can_tx
// ----------------------------------------------------------------------------
module can_tx_sched
    import can_pkg::*;
#(
    parameter int NUM_MBOX     = 4,
    parameter int CLKS_PER_BIT = 10,
    parameter int IFS_BITS     = 3,
    parameter int MAX_RETRY    = 3,
    parameter int TIMEOUT_CLKS = 2048
) (
    input  logic                            i_Clock,
    input  logic                            i_Rst_n,
    input  logic [NUM_MBOX-1:0]             i_Req,
    input  logic [CAN_ID_W*NUM_MBOX-1:0]    i_Id,
    input  logic [CAN_DLC_W*NUM_MBOX-1:0]   i_Len,
    input  logic [CAN_DATA_W*NUM_MBOX-1:0]  i_Data,
    output logic [NUM_MBOX-1:0]             o_Done,
    output logic [NUM_MBOX-1:0]             o_Err,
    output logic                            o_Busy,
    output logic                            o_Tx_DV,
    output logic [CAN_ID_W-1:0]             o_Tx_Id,
    output logic [CAN_DLC_W-1:0]            o_Tx_Len,
    output logic [CAN_DATA_W-1:0]           o_Tx_Data,
    input  logic                            i_Tx_Done,
    input  logic                            i_Tx_Ack
);

    localparam int IDX_W   = (NUM_MBOX > 1) ? $clog2(NUM_MBOX) : 1;
    localparam int IFS_CYC = IFS_BITS * CLKS_PER_BIT;
    localparam int WD_W    = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam int IFS_W   = $clog2(IFS_CYC + 1);
    localparam int RTY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    sched_state_t          r_State;
    can_frame_t            r_Frame;
    logic [NUM_MBOX-1:0]   r_Grant;
    logic [NUM_MBOX-1:0]   r_Done;
    logic [NUM_MBOX-1:0]   r_Err;
    logic                  r_Tx_DV;
    logic                  r_Relaunch;
    logic [RTY_W-1:0]      r_Retry;
    logic [WD_W-1:0]       r_Wd;
    logic [IFS_W-1:0]      r_Ifs;

    logic                  w_Sel_Valid;
    logic [NUM_MBOX-1:0]   w_Sel_Grant;
    logic [IDX_W-1:0]      w_Sel_Idx;
    can_frame_t            w_Sel_Frame;

    can_prio_sel #(
        .NUM_MBOX (NUM_MBOX),
        .IDX_W    (IDX_W)
    ) u_prio_sel (
        .i_Req   (i_Req),
        .i_Id    (i_Id),
        .o_Valid (w_Sel_Valid),
        .o_Grant (w_Sel_Grant),
        .o_Idx   (w_Sel_Idx)
    );

    always_comb begin
        w_Sel_Frame      = '0;
        w_Sel_Frame.id   = i_Id[CAN_ID_W*w_Sel_Idx +: CAN_ID_W];
        w_Sel_Frame.dlc  = i_Len[CAN_DLC_W*w_Sel_Idx +: CAN_DLC_W];
        w_Sel_Frame.data = i_Data[CAN_DATA_W*w_Sel_Idx +: CAN_DATA_W];
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_State    <= IDLE;
            r_Frame    <= '0;
            r_Grant    <= '0;
            r_Done     <= '0;
            r_Err      <= '0;
            r_Tx_DV    <= 1'b0;
            r_Relaunch <= 1'b0;
            r_Retry    <= '0;
            r_Wd       <= '0;
            r_Ifs      <= '0;
        end else begin
            r_Tx_DV <= 1'b0;
            r_Done  <= '0;
            r_Err   <= '0;
            case (r_State)
                IDLE: begin
                    if (|i_Req) r_State <= SELECT;
                end
                SELECT: begin
                    // A request withdrawn in the same cycle leaves no winner;
                    // fall back to IDLE rather than launch an empty frame.
                    if (w_Sel_Valid) begin
                        r_Frame <= w_Sel_Frame;
                        r_Grant <= w_Sel_Grant;
                        r_Retry <= '0;
                        r_State <= LAUNCH;
                    end else begin
                        r_State <= IDLE;
                    end
                end
                LAUNCH: begin
                    r_Tx_DV    <= 1'b1;
                    r_Wd       <= WD_W'(TIMEOUT_CLKS - 1);
                    r_Relaunch <= 1'b0;
                    r_State    <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    // i_Tx_Done takes precedence over a watchdog expiring in
                    // the same cycle.
                    if (i_Tx_Done) begin
                        if (i_Tx_Ack) begin
                            r_Done <= r_Grant;
                        end else if (r_Retry < RTY_W'(MAX_RETRY)) begin
                            r_Retry    <= r_Retry + 1'b1;
                            r_Relaunch <= 1'b1;
                        end else begin
                            r_Err <= r_Grant;
                        end
                        r_Ifs   <= IFS_W'(IFS_CYC);
                        r_State <= IFS;
                    end else if (r_Wd == '0) begin
                        r_Err   <= r_Grant;
                        r_Ifs   <= IFS_W'(IFS_CYC);
                        r_State <= IFS;
                    end else begin
                        r_Wd <= r_Wd - 1'b1;
                    end
                end
                IFS: begin
                    // Loaded with IFS_CYC on entry, so the state lasts
                    // exactly IFS_CYC cycles.
                    if (r_Ifs <= IFS_W'(1)) begin
                        r_Ifs   <= '0;
                        r_State <= r_Relaunch ? LAUNCH : IDLE;
                    end else begin
                        r_Ifs <= r_Ifs - 1'b1;
                    end
                end
                default: r_State <= IDLE;
            endcase
        end
    end

    assign o_Done    = r_Done;
    assign o_Err     = r_Err;
    assign o_Busy    = (r_State != IDLE);
    assign o_Tx_DV   = r_Tx_DV;
    assign o_Tx_Id   = r_Frame.id;
    assign o_Tx_Len  = r_Frame.dlc;
    assign o_Tx_Data = r_Frame.data;

endmodule

// File: tb/tb_can_tx_sched.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_can_tx_sched
// Directed bench for can_tx_sched with default parameters (4 mailboxes,
// 10 clocks/bit, 3-bit IFS = 30 cycles, 3 retries, 2048-cycle watchdog).
// Inputs are driven and outputs sampled on the falling edge; cyc counts
// falling edges so cycle arithmetic below is in whole clocks.
// ----------------------------------------------------------------------------
module tb_can_tx_sched;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req;
    logic [10:0]  id_a  [4];
    logic [3:0]   len_a [4];
    logic [63:0]  dat_a [4];
    logic [43:0]  id_bus;
    logic [15:0]  len_bus;
    logic [255:0] dat_bus;
    logic [3:0]   done, err;
    logic         busy, tx_dv, tx_done, tx_ack;
    logic [10:0]  tx_id;
    logic [3:0]   tx_len;
    logic [63:0]  tx_data;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    assign id_bus  = {id_a[3], id_a[2], id_a[1], id_a[0]};
    assign len_bus = {len_a[3], len_a[2], len_a[1], len_a[0]};
    assign dat_bus = {dat_a[3], dat_a[2], dat_a[1], dat_a[0]};

    can_tx_sched #(
        .NUM_MBOX     (4),
        .CLKS_PER_BIT (10),
        .IFS_BITS     (3),
        .MAX_RETRY    (3),
        .TIMEOUT_CLKS (2048)
    ) dut (
        .i_Clock   (clk),
        .i_Rst_n   (rst_n),
        .i_Req     (req),
        .i_Id      (id_bus),
        .i_Len     (len_bus),
        .i_Data    (dat_bus),
        .o_Done    (done),
        .o_Err     (err),
        .o_Busy    (busy),
        .o_Tx_DV   (tx_dv),
        .o_Tx_Id   (tx_id),
        .o_Tx_Len  (tx_len),
        .o_Tx_Data (tx_data),
        .i_Tx_Done (tx_done),
        .i_Tx_Ack  (tx_ack)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic wait_dv(input int max, input string tag, output int at);
        at = -1;
        for (int i = 0; i < max; i++) begin
            step(1);
            if (tx_dv === 1'b1) begin
                at = cyc;
                break;
            end
        end
        chk(tag, tx_dv, 1'b1);
    endtask

    task automatic wait_idle(input int max, input string tag);
        for (int i = 0; i < max; i++) begin
            step(1);
            if (busy === 1'b0) break;
        end
        chk(tag, busy, 1'b0);
    endtask

    // Drive a one-cycle i_Tx_Done with the given ACK; returns the cycle it was
    // presented in and leaves the bench on the following cycle (pulse cycle).
    task automatic tx_end(input logic ack, output int d);
        tx_done = 1'b1;
        tx_ack  = ack;
        d = cyc;
        step(1);
        tx_done = 1'b0;
        tx_ack  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        int at, prev, d, extra, eseen;
        int exp_idx [4];
        logic [10:0] exp_id [4];

        rst_n = 1'b0; req = '0; tx_done = 1'b0; tx_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            id_a[k] = '0; len_a[k] = '0; dat_a[k] = '0;
        end

        // Reset state
        step(3);
        chk("rst_busy", busy, 1'b0);
        chk("rst_dv", tx_dv, 1'b0);
        chk("rst_id", tx_id, 11'h0);
        chk("rst_len", tx_len, 4'h0);
        chk("rst_data", tx_data, 64'h0);
        chk("rst_done_err", {done, err}, 8'h00);
        rst_n = 1'b1;
        step(2);

        // Single request: strobe 3 cycles after request, frame latched,
        // o_Done[0] once, IDLE after 30 cycles of IFS.
        id_a[0] = 11'h014; len_a[0] = 4'd1; dat_a[0] = 64'hAAAA_AAAA_AAAA_AAAA;
        req = 4'b0001;
        step(1); chk("t1_dv_c1", tx_dv, 1'b0);
        step(1); chk("t1_dv_c2", tx_dv, 1'b0);
        step(1); chk("t1_dv_c3", tx_dv, 1'b1);
        chk("t1_id", tx_id, 11'h014);
        chk("t1_len", tx_len, 4'd1);
        chk("t1_data", tx_data, 64'hAAAA_AAAA_AAAA_AAAA);
        step(1); chk("t1_dv_width", tx_dv, 1'b0);
        step(5);
        tx_end(1'b1, d);
        chk("t1_done", done, 4'b0001);
        chk("t1_err", err, 4'b0000);
        req = 4'b0000;
        step(1); chk("t1_done_width", done, 4'b0000);
        step(28); chk("t1_busy_ifs_end", busy, 1'b1);   // cycle d+30
        step(1);  chk("t1_idle", busy, 1'b0);           // cycle d+31

        // Tx_Done while idle is ignored
        tx_end(1'b1, d);
        chk("idle_txdone_ignored", {busy, done, err}, 9'h000);

        // Arbitration: ids {100, 014, 7FF, 014} -> mbox 1, 3, 0, 2
        id_a[0] = 11'h100; id_a[1] = 11'h014; id_a[2] = 11'h7FF; id_a[3] = 11'h014;
        len_a[0] = 4'd2; len_a[1] = 4'd3; len_a[2] = 4'd4; len_a[3] = 4'd5;
        dat_a[0] = 64'h1000_0000_0000_0000; dat_a[1] = 64'h2000_0000_0000_0001;
        dat_a[2] = 64'h3000_0000_0000_0002; dat_a[3] = 64'h4000_0000_0000_0003;
        exp_idx = '{1, 3, 0, 2};
        exp_id  = '{11'h014, 11'h014, 11'h100, 11'h7FF};
        req = 4'b1111;
        for (int j = 0; j < 4; j++) begin
            wait_dv(100, "t2_dv", at);
            chk("t2_id", tx_id, exp_id[j]);
            chk("t2_len", tx_len, 4'(exp_idx[j] + 2));
            chk("t2_data", tx_data, dat_a[exp_idx[j]]);
            step(3);
            tx_end(1'b1, d);
            chk("t2_done", done, 4'b0001 << exp_idx[j]);
            req[exp_idx[j]] = 1'b0;
        end
        wait_idle(100, "t2_idle");

        // No ACK ever: 4 launches, each relaunch 32 cycles after the prior
        // Tx_Done (30 IFS cycles, one LAUNCH cycle, then the strobe).
        id_a[2] = 11'h123; len_a[2] = 4'd4; dat_a[2] = 64'h5555_0000_FFFF_1234;
        req = 4'b0100;
        prev = 0;
        for (int a = 0; a < 4; a++) begin
            wait_dv(100, "t3_dv", at);
            if (a > 0) chk("t3_relaunch_gap", 64'(at - prev), 64'd32);
            chk("t3_id", tx_id, 11'h123);
            step(4);
            tx_end(1'b0, prev);
            chk("t3_no_done", done, 4'b0000);
            chk("t3_err", err, (a == 3) ? 4'b0100 : 4'b0000);
        end
        req = 4'b0000;
        extra = 0;
        for (int i = 0; i < 60; i++) begin
            step(1);
            if (tx_dv === 1'b1 || done !== 4'b0000) extra++;
        end
        chk("t3_no_extra_activity", extra, 0);
        chk("t3_idle", busy, 1'b0);

        // NACK once, then ACK: identical frame relaunched even though the
        // mailbox contents change while in flight.
        id_a[3] = 11'h2A5; len_a[3] = 4'd8; dat_a[3] = 64'h0123_4567_89AB_CDEF;
        req = 4'b1000;
        wait_dv(100, "t4_dv1", at);
        chk("t4_id1", tx_id, 11'h2A5);
        id_a[3] = 11'h000; len_a[3] = 4'd2; dat_a[3] = 64'h0;
        step(3);
        tx_end(1'b0, d);
        chk("t4_no_done1", {done, err}, 8'h00);
        wait_dv(100, "t4_dv2", at);
        chk("t4_id2", tx_id, 11'h2A5);
        chk("t4_len2", tx_len, 4'd8);
        chk("t4_data2", tx_data, 64'h0123_4567_89AB_CDEF);
        step(3);
        tx_end(1'b1, d);
        chk("t4_done", done, 4'b1000);
        chk("t4_no_err", err, 4'b0000);
        req = 4'b0000;
        wait_idle(100, "t4_idle");

        // Watchdog: Tx_Done never arrives
        id_a[1] = 11'h050;
        req = 4'b0010;
        wait_dv(100, "t5_dv", at);
        eseen = -1;
        for (int i = 0; i < 2200; i++) begin
            step(1);
            if (err !== 4'b0000) begin
                eseen = cyc;
                break;
            end
        end
        chk("t5_err", err, 4'b0010);
        chk("t5_err_latency", 64'(eseen - at), 64'd2048);
        chk("t5_no_done", done, 4'b0000);
        req = 4'b0000;
        step(29); chk("t5_busy_ifs_end", busy, 1'b1);
        step(1);  chk("t5_idle", busy, 1'b0);

        // Asynchronous reset during WAIT_DONE, then fresh arbitration
        id_a[0] = 11'h003; len_a[0] = 4'd6; dat_a[0] = 64'hDEAD_BEEF_0000_0006;
        req = 4'b0001;
        wait_dv(100, "t6_dv", at);
        step(5);
        chk("t6_busy_before", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_busy", busy, 1'b0);
        chk("t6_async_frame", {tx_id, tx_len, tx_data}, 0);
        chk("t6_async_flags", {tx_dv, done, err}, 9'h000);
        eseen = 0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            if (err !== 4'b0000) eseen++;
        end
        chk("t6_no_err", eseen, 0);
        id_a[2] = 11'h001; len_a[2] = 4'd7;
        req = 4'b0101;
        rst_n = 1'b1;
        step(3);
        chk("t6_dv_after_rst", tx_dv, 1'b1);
        chk("t6_id_after_rst", tx_id, 11'h001);
        chk("t6_len_after_rst", tx_len, 4'd7);
        step(2);
        tx_end(1'b1, d);
        chk("t6_done", done, 4'b0100);
        req = 4'b0000;
        wait_idle(100, "t6_idle");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
